// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, refill FSM states and address helpers
package cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 25;
  localparam int LINE_W     = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } refill_state_t;

  // Byte address of the first word of the line containing addr
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & 32'hFFFF_FFF0;
  endfunction

endpackage

// File: rtl/refill_timeout.sv
// rtl/refill_timeout.sv - 8-bit response wait counter with clear, enable and expired flag
module refill_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q;

  // Count cycles spent waiting; hold once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - critical-word-first cache line refill engine
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_valid,
  input  logic [31:0]  miss_addr,
  output logic         miss_ready,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic         crit_valid,
  output logic [31:0]  crit_data,
  output logic         line_valid,
  output logic [31:0]  line_addr,
  output logic [127:0] line_data,
  output logic         line_err
);

  localparam int BASE_W = TAG_W + INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

  refill_state_t       state_q;
  logic [BASE_W-1:0]   base_q;
  logic [OFFSET_W-1:0] start_q;
  logic [OFFSET_W-1:0] count_q;
  logic [OFFSET_W-1:0] cur_off;
  logic [LINE_W-1:0]   buf_q;
  logic [LINE_W-1:0]   buf_d;
  logic [LINE_W-1:0]   line_data_q;
  logic [31:0]         line_addr_q;
  logic [31:0]         crit_data_q;
  logic                crit_valid_q;
  logic                expired;

  // 2-bit add wraps naturally, giving start, start+1, ... 3 -> 0
  assign cur_off = start_q + count_q;

  // Assembly buffer with the incoming response merged into its slot
  always_comb begin
    buf_d = buf_q;
    buf_d[{cur_off, 5'd0} +: 32] = mem_rdata;
  end

  refill_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ST_WAIT),
    .en_i     ((state_q == ST_WAIT) && !mem_rvalid),
    .expired_o(expired)
  );

  // Refill FSM: issue one read at a time, collect responses, publish the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      start_q      <= '0;
      count_q      <= '0;
      buf_q        <= '0;
      line_data_q  <= '0;
      line_addr_q  <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      crit_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (miss_valid) begin
            base_q  <= miss_addr[31:4];
            start_q <= miss_addr[3:2];
            count_q <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (expired) begin
            // Partial buffer is abandoned; the published line stays as it was
            state_q <= ST_IDLE;
          end else if (mem_rvalid) begin
            buf_q <= buf_d;
            if (count_q == '0) begin
              crit_valid_q <= 1'b1;
              crit_data_q  <= mem_rdata;
            end
            if (count_q == LAST_WORD) begin
              line_data_q <= buf_d;
              line_addr_q <= line_base(mem_addr);
              state_q     <= ST_DONE;
            end else begin
              count_q <= count_q + 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign miss_ready = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = {base_q, cur_off, 2'b00};
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign line_valid = (state_q == ST_DONE);
  assign line_addr  = line_addr_q;
  assign line_data  = line_data_q;
  assign line_err   = (state_q == ST_WAIT) && expired;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         line_err;

  cache_refill_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .crit_valid(crit_valid), .crit_data(crit_data), .line_valid(line_valid),
    .line_addr(line_addr), .line_data(line_data), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory contents for the current line, indexed by word slot
  logic [31:0]  mem_words [4];
  logic [31:0]  req_q [$];
  int           crit_cyc, crit_cnt, line_cyc, line_cnt, err_cyc, err_cnt, ready_cyc, addr_moves;
  logic [31:0]  crit_seen, line_a_seen;
  logic [127:0] line_d_seen;

  // Reference: k-th requested address walks the line from the missed word, wrapping
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int k);
    int s;
    s = int'(a[3:2]);
    return {a[31:4], 4'b0000} + 32'(((s + k) % 4) * 4);
  endfunction

  function automatic logic [127:0] exp_line();
    return {mem_words[3], mem_words[2], mem_words[1], mem_words[0]};
  endfunction

  task automatic fill_words(input bit fixed);
    for (int i = 0; i < 4; i++) mem_words[i] = fixed ? 32'h0000_0AA0 + 32'(i) : $urandom;
  endtask

  // Memory responder and observer for one miss; cycle 1 is the cycle after acceptance
  task automatic do_fill(input logic [31:0] addr, input int stall, input int delay,
                         input int withhold, input bit noise, input int abort_at);
    bit pending;
    int pend_wait, req_wait, word;
    logic [31:0] stall_addr, acc_addr;
    req_q.delete();
    crit_cnt = 0; line_cnt = 0; err_cnt = 0; addr_moves = 0;
    crit_cyc = -1; line_cyc = -1; err_cyc = -1; ready_cyc = -1;
    pending = 0; pend_wait = 0; req_wait = 0; word = 0;
    stall_addr = '0; acc_addr = '0;
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(posedge clk); @(negedge clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == abort_at) begin
        rst_n = 1'b0; miss_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        return;
      end
      if (crit_valid) begin crit_cnt++; crit_cyc = cyc; crit_seen = crit_data; end
      if (line_valid) begin line_cnt++; line_cyc = cyc; line_d_seen = line_data; line_a_seen = line_addr; end
      if (line_err) begin err_cnt++; err_cyc = cyc; end
      if (miss_ready && (line_cnt + err_cnt) > 0) begin
        ready_cyc = cyc;
        miss_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        return;
      end
      miss_valid = noise;
      miss_addr  = $urandom;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pending) begin
        if (pend_wait > 0) pend_wait--;
        else if (word != withhold) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_words[acc_addr[3:2]];
          pending    = 0;
          word++;
        end
      end else if (mem_req) begin
        if (req_wait == 0) stall_addr = mem_addr;
        else if (mem_addr !== stall_addr) addr_moves++;
        if (noise) mem_rvalid = 1'b1;
        if (req_wait < stall) req_wait++;
        else begin
          mem_ready = 1'b1;
          acc_addr  = mem_addr;
          req_q.push_back(mem_addr);
          req_wait  = 0;
          pending   = 1;
          pend_wait = delay;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    miss_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready: got %b expected 1", miss_ready); end
    checks++; if ({mem_req, crit_valid, line_valid, line_err} !== 4'b0) begin errors++;
      $display("FAIL rst_strobes: got %b expected 0000", {mem_req, crit_valid, line_valid, line_err}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (crit_data !== 32'h0) begin errors++; $display("FAIL rst_crit_data: got %h expected 0", crit_data); end
    checks++; if (line_addr !== 32'h0) begin errors++; $display("FAIL rst_line_addr: got %h expected 0", line_addr); end
    checks++; if (line_data !== 128'h0) begin errors++; $display("FAIL rst_line_data: got %h expected 0", line_data); end
    @(negedge clk);
  endtask

  task automatic test_zero_wait;
    fill_words(1'b1);
    do_fill(32'h0000_1040, 0, 0, -1, 1'b0, -1);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL zw_req_count: got %0d expected 4", req_q.size()); end
    for (int k = 0; k < req_q.size() && k < 4; k++) begin
      checks++; if (req_q[k] !== 32'h0000_1040 + 32'(4 * k)) begin errors++;
        $display("FAIL zw_addr%0d: got %h expected %h", k, req_q[k], 32'h0000_1040 + 32'(4 * k)); end
    end
    checks++; if (line_d_seen !== {32'hAA3, 32'hAA2, 32'hAA1, 32'hAA0}) begin errors++;
      $display("FAIL zw_line_data: got %h expected %h", line_d_seen, {32'hAA3, 32'hAA2, 32'hAA1, 32'hAA0}); end
    checks++; if (line_a_seen !== 32'h0000_1040) begin errors++; $display("FAIL zw_line_addr: got %h expected 00001040", line_a_seen); end
    checks++; if (line_cyc != 9 || line_cnt != 1) begin errors++; $display("FAIL zw_line_cycle: got %0d x%0d expected 9 x1", line_cyc, line_cnt); end
    checks++; if (crit_cyc != 3 || crit_cnt != 1) begin errors++; $display("FAIL zw_crit_cycle: got %0d x%0d expected 3 x1", crit_cyc, crit_cnt); end
    checks++; if (crit_seen !== 32'hAA0) begin errors++; $display("FAIL zw_crit_data: got %h expected aa0", crit_seen); end
    checks++; if (ready_cyc != 10) begin errors++; $display("FAIL zw_ready_cycle: got %0d expected 10", ready_cyc); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h2078; exp_seq[1] = 32'h207C; exp_seq[2] = 32'h2070; exp_seq[3] = 32'h2074;
    fill_words(1'b0);
    do_fill(32'h0000_2078, 0, 0, -1, 1'b0, -1);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL wrap_req_count: got %0d expected 4", req_q.size()); end
    for (int k = 0; k < req_q.size() && k < 4; k++) begin
      checks++; if (req_q[k] !== exp_seq[k]) begin errors++;
        $display("FAIL wrap_addr%0d: got %h expected %h", k, req_q[k], exp_seq[k]); end
    end
    checks++; if (crit_seen !== mem_words[2]) begin errors++; $display("FAIL wrap_crit_data: got %h expected %h", crit_seen, mem_words[2]); end
    checks++; if (line_d_seen !== exp_line()) begin errors++; $display("FAIL wrap_line_data: got %h expected %h", line_d_seen, exp_line()); end
    checks++; if (line_a_seen !== 32'h0000_2070) begin errors++; $display("FAIL wrap_line_addr: got %h expected 00002070", line_a_seen); end
  endtask

  task automatic test_backpressure;
    logic [31:0] a;
    a = $urandom;
    fill_words(1'b0);
    do_fill(a, 3, 0, -1, 1'b0, -1);
    checks++; if (line_cyc != 21) begin errors++; $display("FAIL bp_line_cycle: got %0d expected 21", line_cyc); end
    checks++; if (addr_moves != 0) begin errors++; $display("FAIL bp_addr_stable: got %0d changes expected 0", addr_moves); end
    checks++; if (line_d_seen !== exp_line()) begin errors++; $display("FAIL bp_line_data: got %h expected %h", line_d_seen, exp_line()); end
  endtask

  task automatic test_timeout;
    logic [127:0] prev;
    prev = line_data;
    fill_words(1'b0);
    do_fill($urandom, 0, 0, 1, 1'b0, -1);
    checks++; if (err_cyc != 3 + TMO + 1 || err_cnt != 1) begin errors++;
      $display("FAIL to_err_cycle: got %0d x%0d expected %0d x1", err_cyc, err_cnt, 3 + TMO + 1); end
    checks++; if (line_cnt != 0) begin errors++; $display("FAIL to_no_line: got %0d line pulses expected 0", line_cnt); end
    checks++; if (ready_cyc != err_cyc + 1) begin errors++; $display("FAIL to_ready: got %0d expected %0d", ready_cyc, err_cyc + 1); end
    checks++; if (line_data !== prev) begin errors++; $display("FAIL to_line_kept: got %h expected %h", line_data, prev); end
    checks++; if (req_q.size() != 2) begin errors++; $display("FAIL to_req_count: got %0d expected 2", req_q.size()); end
  endtask

  task automatic test_ignore;
    logic [31:0]  a;
    logic [127:0] prev;
    int bad;
    a = $urandom;
    fill_words(1'b0);
    do_fill(a, 1, 1, -1, 1'b1, -1);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL ign_req_count: got %0d expected 4", req_q.size()); end
    for (int k = 0; k < req_q.size() && k < 4; k++) begin
      checks++; if (req_q[k] !== exp_addr(a, k)) begin errors++;
        $display("FAIL ign_addr%0d: got %h expected %h", k, req_q[k], exp_addr(a, k)); end
    end
    checks++; if (line_d_seen !== exp_line()) begin errors++; $display("FAIL ign_line_data: got %h expected %h", line_d_seen, exp_line()); end
    checks++; if (line_cyc != 17) begin errors++; $display("FAIL ign_line_cycle: got %0d expected 17", line_cyc); end
    prev = line_data;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(posedge clk); @(negedge clk);
      if (!miss_ready || mem_req || crit_valid || line_valid) bad++;
    end
    mem_rvalid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_idle_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (line_data !== prev) begin errors++; $display("FAIL ign_idle_line: got %h expected %h", line_data, prev); end
  endtask

  task automatic test_reset_mid_fill;
    logic [31:0] a;
    fill_words(1'b0);
    do_fill($urandom, 0, 0, -1, 1'b0, 5);
    #1;
    checks++; if ({miss_ready, mem_req, crit_valid, line_valid, line_err} !== 5'b10000) begin errors++;
      $display("FAIL mid_rst_strobes: got %b expected 10000", {miss_ready, mem_req, crit_valid, line_valid, line_err}); end
    checks++; if ({mem_addr, line_addr, crit_data} !== 96'h0) begin errors++;
      $display("FAIL mid_rst_addrs: got %h expected 0", {mem_addr, line_addr, crit_data}); end
    checks++; if (line_data !== 128'h0) begin errors++; $display("FAIL mid_rst_line: got %h expected 0", line_data); end
    @(negedge clk);
    rst_n = 1'b1;
    a = $urandom;
    fill_words(1'b0);
    do_fill(a, 0, 0, -1, 1'b0, -1);
    checks++; if (line_d_seen !== exp_line() || line_a_seen !== {a[31:4], 4'b0}) begin errors++;
      $display("FAIL mid_refill: got %h@%h expected %h@%h", line_d_seen, line_a_seen, exp_line(), {a[31:4], 4'b0}); end
    checks++; if (line_cyc != 9) begin errors++; $display("FAIL mid_refill_cycle: got %0d expected 9", line_cyc); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    int s, d;
    for (int n = 0; n < 6; n++) begin
      a = $urandom;
      s = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      fill_words(1'b0);
      do_fill(a, s, d, -1, 1'b0, -1);
      checks++; if (req_q.size() != 4) begin errors++; $display("FAIL b2b%0d_req_count: got %0d expected 4", n, req_q.size()); end
      for (int k = 0; k < req_q.size() && k < 4; k++) begin
        checks++; if (req_q[k] !== exp_addr(a, k)) begin errors++;
          $display("FAIL b2b%0d_addr%0d: got %h expected %h", n, k, req_q[k], exp_addr(a, k)); end
      end
      checks++; if (line_d_seen !== exp_line()) begin errors++; $display("FAIL b2b%0d_line_data: got %h expected %h", n, line_d_seen, exp_line()); end
      checks++; if (line_a_seen !== {a[31:4], 4'b0}) begin errors++; $display("FAIL b2b%0d_line_addr: got %h expected %h", n, line_a_seen, {a[31:4], 4'b0}); end
      checks++; if (line_cyc != 9 + 4 * (s + d)) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", n, line_cyc, 9 + 4 * (s + d)); end
      checks++; if (crit_cyc != 3 + s + d || crit_seen !== mem_words[a[3:2]]) begin errors++;
        $display("FAIL b2b%0d_crit: got %h@%0d expected %h@%0d", n, crit_seen, crit_cyc, mem_words[a[3:2]], 3 + s + d); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_ignore();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-side refill engine for the direct-mapped 8-line, 4-word-per-line instruction/data cache. It accepts one miss address at a time and fetches the four 32-bit words of the containing line from word-wide main memory, critical word first. It assembles them into the 128-bit line image the cache writes as `{valid, tag, data_line}` and presents that line with a one-cycle strobe. It sits between the cache miss path and the memory port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for one memory response before abandoning the fill (range 1..255).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `miss_valid` input 1: miss request.
- `miss_addr` input 32: byte address that missed.
- `miss_ready` output 1: high only in IDLE.
- `mem_req` output 1: memory read request, valid/ready with `mem_ready`.
- `mem_addr` output 32: word address (byte address, bits [1:0]=00).
- `mem_ready` input 1: memory accepts request.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 32: read data.
- `crit_valid` output 1: one-cycle pulse when the missed word arrives.
- `crit_data` output 32: missed word, valid with `crit_valid`.
- `line_valid` output 1: one-cycle pulse, full line ready.
- `line_addr` output 32: line base, `{miss_addr[31:4], 4'b0}`.
- `line_data` output 128: word k at bits [32k+31:32k], k = address bits [3:2].
- `line_err` output 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `miss_ready`=1. On `miss_valid`, latch `miss_addr[31:4]` as base and `miss_addr[3:2]` as start offset. Set word counter to 0 and go to REQ.
- REQ: `mem_req`=1, `mem_addr`={base, cur_off, 2'b00}, with cur_off = (start + count) mod 4. The 2-bit wrap gives order start, start+1, …, wrapping 3→0. Stay until `mem_ready`, then go to WAIT with the timer cleared.
- WAIT: at most one read is outstanding. On `mem_rvalid`, write `mem_rdata` into slot cur_off. If count==0, pulse `crit_valid` with `crit_data`=`mem_rdata` on the next cycle. If count==3, go to DONE; otherwise increment count and go to REQ.
- WAIT timer: increments each cycle without `mem_rvalid`. Reaching `TIMEOUT_CYCLES` pulses `line_err`, discards the partial line, and returns to IDLE. `line_valid` is not asserted.
- DONE: `line_valid`=1 for exactly one cycle, `line_data` and `line_addr` stable; then IDLE.
- `mem_rvalid` outside WAIT is ignored, including in the cycle `mem_ready` is accepted.
- `miss_valid` outside IDLE is ignored and not queued.
- `line_data` holds its last value between fills. Slots are overwritten only by new responses.

## Timing
- Reset (async assert, sync deassert seen at next edge): state IDLE, `miss_ready`=1. All other outputs, `mem_addr`, `line_addr` and `line_data` are 0; counters are 0.
- Reset mid-fill aborts immediately. No `line_valid` or `line_err` is produced.
- Zero-wait memory (`mem_ready`=1, `mem_rvalid` one cycle after acceptance), miss accepted at edge 0:
  - `mem_req` is high in cycles 1, 3, 5, 7.
  - Data is captured at edges 2, 4, 6, 8.
  - `crit_valid` is high in cycle 3.
  - `line_valid` is high in cycle 9.
  - `miss_ready` is high again in cycle 10.
- Minimum miss-to-line latency is 9 cycles. Each `mem_ready` stall cycle or `mem_rvalid` delay cycle adds one cycle.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Structure
- Shared `cache_pkg`:
  - constants `LINE_WORDS`=4, `OFFSET_W`=2, `INDEX_W`=3, `TAG_W`=25, `LINE_W`=128;
  - state enum `refill_state_t`;
  - a `line_base()` helper.
- One sub-module, `refill_timeout`: 8-bit counter with clear, enable and an expired flag.
- The FSM, word counter and line register live in the top.

## Test plan
- Zero-wait fill, miss 0x0000_1040:
  - mem_addr sequence is 0x1040, 0x1044, 0x1048, 0x104C;
  - data AA0..AA3 gives line_data {AA3,AA2,AA1,AA0};
  - line_valid in cycle 9 with line_addr 0x0000_1040.
- Critical-word-first wrap, miss 0x0000_2078:
  - addresses 0x2078, 0x207C, 0x2070, 0x2074;
  - crit_data equals the first response;
  - words land in slots 2, 3, 0, 1.
- Backpressure: mem_ready low for 3 cycles on every request → line_valid in cycle 21; mem_addr stable while stalled.
- Timeout (TIMEOUT_CYCLES=8): withhold mem_rvalid on the 2nd word → line_err pulse 8 cycles after acceptance, no line_valid, miss_ready high the next cycle.
- Ignore rules:
  - a second miss_valid during a fill → no effect;
  - a spurious mem_rvalid in IDLE → line_data unchanged.
- Reset mid-fill after 2 words → all outputs reset immediately; a new miss then completes a normal fill.
